// File: rtl/wshb_arbiter.sv
// Two-master / one-slave Wishbone arbiter: registered round-robin grant with a
// hold limit, combinational bus mux decoded from the grant state.
module wshb_arbiter #(
    parameter int ADR_W      = 32,
    parameter int DATA_BYTES = 4,
    parameter int MAX_HOLD   = 64
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,

    input  logic                    m0_cyc,
    input  logic                    m0_stb,
    input  logic                    m0_we,
    input  logic [ADR_W-1:0]        m0_adr,
    input  logic [8*DATA_BYTES-1:0] m0_dat_ms,
    input  logic [DATA_BYTES-1:0]   m0_sel,
    input  logic [2:0]              m0_cti,
    input  logic [1:0]              m0_bte,
    output logic [8*DATA_BYTES-1:0] m0_dat_sm,
    output logic                    m0_ack,
    output logic                    m0_err,
    output logic                    m0_rty,

    input  logic                    m1_cyc,
    input  logic                    m1_stb,
    input  logic                    m1_we,
    input  logic [ADR_W-1:0]        m1_adr,
    input  logic [8*DATA_BYTES-1:0] m1_dat_ms,
    input  logic [DATA_BYTES-1:0]   m1_sel,
    input  logic [2:0]              m1_cti,
    input  logic [1:0]              m1_bte,
    output logic [8*DATA_BYTES-1:0] m1_dat_sm,
    output logic                    m1_ack,
    output logic                    m1_err,
    output logic                    m1_rty,

    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [ADR_W-1:0]        s_adr,
    output logic [8*DATA_BYTES-1:0] s_dat_ms,
    output logic [DATA_BYTES-1:0]   s_sel,
    output logic [2:0]              s_cti,
    output logic [1:0]              s_bte,
    input  logic [8*DATA_BYTES-1:0] s_dat_sm,
    input  logic                    s_ack,
    input  logic                    s_err,
    input  logic                    s_rty
);

    localparam int HW             = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam bit HOLD_EN        = (MAX_HOLD > 0);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;

    logic            own_cyc;
    logic            oth_cyc;
    logic            own_id;
    state_e          oth_state;
    logic            beat_term;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        own_id    = (state_q == G1);
        own_cyc   = own_id ? m1_cyc : m0_cyc;
        oth_cyc   = own_id ? m0_cyc : m1_cyc;
        oth_state = own_id ? G0 : G1;
        beat_term = s_stb & (s_ack | s_err | s_rty);
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (m0_cyc && m1_cyc) begin
                    state_d = last_q ? G0 : G1;
                end else if (m0_cyc) begin
                    state_d = G0;
                end else if (m1_cyc) begin
                    state_d = G1;
                end
            end
            G0, G1: begin
                if (!own_cyc) begin
                    last_d     = own_id;
                    hold_cnt_d = '0;
                    state_d    = oth_cyc ? oth_state : IDLE;
                end else if (HOLD_EN && oth_cyc && (hold_cnt_q == HOLD_LIMIT) && beat_term) begin
                    // Preempt only on a terminated beat so no transfer is split.
                    last_d     = own_id;
                    hold_cnt_d = '0;
                    state_d    = oth_state;
                end else if (HOLD_EN && oth_cyc && (hold_cnt_q != HOLD_LIMIT)) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        s_we      = 1'b0;
        s_adr     = '0;
        s_dat_ms  = '0;
        s_sel     = '0;
        s_cti     = '0;
        s_bte     = '0;
        m0_dat_sm = '0;
        m0_ack    = 1'b0;
        m0_err    = 1'b0;
        m0_rty    = 1'b0;
        m1_dat_sm = '0;
        m1_ack    = 1'b0;
        m1_err    = 1'b0;
        m1_rty    = 1'b0;
        case (state_q)
            G0: begin
                s_cyc     = m0_cyc;
                s_stb     = m0_stb;
                s_we      = m0_we;
                s_adr     = m0_adr;
                s_dat_ms  = m0_dat_ms;
                s_sel     = m0_sel;
                s_cti     = m0_cti;
                s_bte     = m0_bte;
                m0_dat_sm = s_dat_sm;
                m0_ack    = s_ack;
                m0_err    = s_err;
                m0_rty    = s_rty;
            end
            G1: begin
                s_cyc     = m1_cyc;
                s_stb     = m1_stb;
                s_we      = m1_we;
                s_adr     = m1_adr;
                s_dat_ms  = m1_dat_ms;
                s_sel     = m1_sel;
                s_cti     = m1_cti;
                s_bte     = m1_bte;
                m1_dat_sm = s_dat_sm;
                m1_ack    = s_ack;
                m1_err    = s_err;
                m1_rty    = s_rty;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for wshb_arbiter: grant latency, tie-break, round-robin,
// hold-limit preemption, error/retry routing and asynchronous reset.
module tb_wshb_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;

    logic        m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_adr = '0, m0_dat_ms = '0;
    logic [3:0]  m0_sel = 4'hF;
    logic [2:0]  m0_cti = '0;
    logic [1:0]  m0_bte = '0;
    logic [31:0] m0_dat_sm;
    logic        m0_ack, m0_err, m0_rty;

    logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_adr = '0, m1_dat_ms = '0;
    logic [3:0]  m1_sel = 4'hF;
    logic [2:0]  m1_cti = '0;
    logic [1:0]  m1_bte = '0;
    logic [31:0] m1_dat_sm;
    logic        m1_ack, m1_err, m1_rty;

    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat_ms;
    logic [3:0]  s_sel;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte;
    logic [31:0] s_dat_sm;
    logic        s_ack, s_err, s_rty;

    // Slave model: zero-wait ack, or ack one cycle after strobe in wait mode.
    logic        wait_mode = 1'b0;
    logic        err_req = 1'b0;
    logic        rty_req = 1'b0;
    logic        ws_q;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] A0 = 32'h0000_0200;
    localparam logic [31:0] A1 = 32'h0000_0300;

    always #5 sys_clk = ~sys_clk;

    assign s_dat_sm = {s_adr[15:0], 16'hBEEF};
    assign s_ack = s_cyc & s_stb & ~err_req & ~rty_req & (wait_mode ? ws_q : 1'b1);
    assign s_err = s_cyc & s_stb & err_req;
    assign s_rty = s_cyc & s_stb & rty_req;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) ws_q <= 1'b0;
        else            ws_q <= s_cyc & s_stb & ~s_ack;
    end

    wshb_arbiter #(.ADR_W(32), .DATA_BYTES(4), .MAX_HOLD(8)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
        .m0_dat_sm(m0_dat_sm), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
        .m1_dat_sm(m1_dat_sm), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
        .s_dat_sm(s_dat_sm), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty)
    );

    function automatic logic [31:0] rdData(input logic [31:0] a);
        return {a[15:0], 16'hBEEF};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int m, input logic cyc, input logic [31:0] adr, input logic we);
        if (m == 0) begin
            m0_cyc = cyc; m0_stb = cyc; m0_adr = adr; m0_we = we; m0_dat_ms = ~adr;
        end else begin
            m1_cyc = cyc; m1_stb = cyc; m1_adr = adr; m1_we = we; m1_dat_ms = ~adr;
        end
    endtask

    task automatic doReset();
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    int  order[$];
    int  b0, b1, t0, t1, first_g0, beats_at_sw, last1_c;
    bit  both, seen;
    logic [31:0] rd_adr;

    initial begin
        // Reset state with a master already requesting
        applyStimulus(0, 1'b1, 32'h0000_1234, 1'b0);
        #12;
        checkOutput("rst_s_cyc", s_cyc, 1'b0);
        checkOutput("rst_s_adr", s_adr, 32'h0);
        checkOutput("rst_m0_dat_sm", m0_dat_sm, 32'h0);
        checkOutput("rst_m0_ack", m0_ack, 1'b0);
        applyStimulus(0, 1'b0, 32'h0, 1'b0);
        doReset();

        // Single master, four reads with a one-wait-state slave
        wait_mode = 1'b1;
        rd_adr = 32'h0000_0100;
        applyStimulus(0, 1'b1, rd_adr, 1'b0);
        #1 checkOutput("t1_s_cyc_before_edge", s_cyc, 1'b0);
        @(negedge sys_clk);
        checkOutput("t1_grant_latency", s_cyc, 1'b1);
        for (int i = 0; i < 4; i++) begin
            seen = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                if (m0_ack) seen = 1'b1;
                else @(negedge sys_clk);
            end
            checkOutput($sformatf("t1_ack_seen_%0d", i), seen, 1'b1);
            checkOutput($sformatf("t1_dat_%0d", i), m0_dat_sm, rdData(rd_adr));
            checkOutput($sformatf("t1_m1_ack_%0d", i), m1_ack, 1'b0);
            rd_adr = rd_adr + 32'd4;
            m0_adr = rd_adr;
            @(negedge sys_clk);
        end
        applyStimulus(0, 1'b0, 32'h0, 1'b0);
        wait_mode = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Tie right after reset goes to m0, then direct handover to m1
        doReset();
        applyStimulus(0, 1'b1, A0, 1'b0);
        applyStimulus(1, 1'b1, A1, 1'b1);
        @(negedge sys_clk);
        checkOutput("t2_tie_grant_m0", s_adr, A0);
        checkOutput("t2_m0_ack1", m0_ack, 1'b1);
        @(negedge sys_clk);
        checkOutput("t2_m0_ack2", m0_ack, 1'b1);
        applyStimulus(0, 1'b0, 32'h0, 1'b0);
        @(negedge sys_clk);
        checkOutput("t2_handover_cyc", s_cyc, 1'b1);
        checkOutput("t2_handover_adr", s_adr, A1);
        checkOutput("t2_m1_ack", m1_ack, 1'b1);
        @(negedge sys_clk);
        applyStimulus(1, 1'b0, 32'h0, 1'b0);
        @(negedge sys_clk);
        checkOutput("t2_idle_after", s_cyc, 1'b0);

        // Round-robin with two-beat transactions and a one-cycle release
        applyStimulus(0, 1'b1, A0 + 32'h10, 1'b0);
        applyStimulus(1, 1'b1, A1 + 32'h10, 1'b1);
        b0 = 0; b1 = 0; t0 = 0; t1 = 0;
        order.delete();
        for (int c = 1; c <= 30; c++) begin
            @(negedge sys_clk);
            if (m0_ack) begin
                b0++;
                if (b0 == 2) begin b0 = 0; t0++; order.push_back(0); m0_cyc = 1'b0; m0_stb = 1'b0; end
            end else if (!m0_cyc && t0 < 2) begin
                m0_cyc = 1'b1; m0_stb = 1'b1;
            end
            if (m1_ack) begin
                b1++;
                if (b1 == 2) begin b1 = 0; t1++; order.push_back(1); m1_cyc = 1'b0; m1_stb = 1'b0; end
            end else if (!m1_cyc && t1 < 2) begin
                m1_cyc = 1'b1; m1_stb = 1'b1;
            end
        end
        checkOutput("t3_tx_count", order.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t3_order_%0d", i), (i < order.size()) ? order[i] : -1, i % 2);
        end

        // Hold limit: m1 bursts 32 beats while m0 requests from cycle 1
        applyStimulus(0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1, 1'b1, 32'h0000_0700, 1'b1);
        b0 = 0; b1 = 0; first_g0 = 0; beats_at_sw = 0; last1_c = 0; both = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge sys_clk);
            if (m0_ack && m1_ack) both = 1'b1;
            if (first_g0 == 0 && s_cyc && s_adr == 32'h0000_0600) begin
                first_g0 = c; beats_at_sw = b1;
            end
            if (m1_ack) begin
                b1++;
                if (b1 == 32) begin last1_c = c; m1_cyc = 1'b0; m1_stb = 1'b0; end
            end
            if (m0_ack) begin
                b0++;
                if (b0 == 4) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
            end
            if (c == 1) applyStimulus(0, 1'b1, 32'h0000_0600, 1'b0);
        end
        checkOutput("t4_preempt_cycle", first_g0, 10);
        checkOutput("t4_m1_beats_before_preempt", beats_at_sw, 9);
        checkOutput("t4_m1_total_acks", b1, 32);
        checkOutput("t4_m0_total_acks", b0, 4);
        checkOutput("t4_m1_last_ack_cycle", last1_c, 36);
        checkOutput("t4_no_double_ack", both, 1'b0);

        // Error and retry routed only to the granted master
        applyStimulus(1, 1'b1, A1, 1'b1);
        err_req = 1'b1;
        @(negedge sys_clk);
        checkOutput("t5_m1_err", m1_err, 1'b1);
        checkOutput("t5_m0_err", m0_err, 1'b0);
        checkOutput("t5_m1_ack", m1_ack, 1'b0);
        applyStimulus(0, 1'b1, A0, 1'b0);
        err_req = 1'b0;
        rty_req = 1'b1;
        #1;
        checkOutput("t5_m1_rty", m1_rty, 1'b1);
        checkOutput("t5_m0_rty", m0_rty, 1'b0);
        checkOutput("t5_m0_dat_zero", m0_dat_sm, 32'h0);
        @(negedge sys_clk);
        rty_req = 1'b0;
        applyStimulus(1, 1'b0, 32'h0, 1'b0);
        @(negedge sys_clk);
        checkOutput("t5_handover_adr", s_adr, A0);
        checkOutput("t5_m0_dat", m0_dat_sm, rdData(A0));
        applyStimulus(0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge sys_clk);

        // Asynchronous reset in the middle of an m1 burst
        applyStimulus(1, 1'b1, A1, 1'b1);
        @(negedge sys_clk);
        checkOutput("t6_pre_cyc", s_cyc, 1'b1);
        checkOutput("t6_pre_m1_ack", m1_ack, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_s_cyc", s_cyc, 1'b0);
        checkOutput("t6_rst_s_stb", s_stb, 1'b0);
        checkOutput("t6_rst_m1_ack", m1_ack, 1'b0);
        applyStimulus(0, 1'b1, A0, 1'b0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        checkOutput("t6_tie_after_reset", s_adr, A0);
        applyStimulus(0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge sys_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wshb_arbiter.md
Name: wshb_arbiter

Overview:
- Two-master / one-slave Wishbone arbiter on the sys_clk domain. It shares the SDRAM Wishbone slave port of the hardware support between two masters:
  - m0: framebuffer reader feeding the vga pixel path.
  - m1: the pattern/stream writer.
- Round-robin grant with a hold limit, so a long writer burst cannot starve the display reader.
- Grant is registered. The data/control mux is combinational from the grant state.

Parameters:
- ADR_W, 32, address width of all ports.
- DATA_BYTES, 4, bus width in bytes; dat width = 8*DATA_BYTES, sel width = DATA_BYTES.
- MAX_HOLD, 64, cycles a master may keep the grant while the other requests; 0 disables preemption.

Ports:
- sys_clk  in  1  system clock (100 MHz).
- sys_rst_n  in  1  asynchronous active-low reset.
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle/strobe/write.
- m0_adr  in  ADR_W  master 0 address.
- m0_dat_ms  in  8*DATA_BYTES  master 0 write data.
- m0_sel  in  DATA_BYTES  byte selects.
- m0_cti  in  3  cycle type identifier.
- m0_bte  in  2  burst type extension.
- m0_dat_sm  out  8*DATA_BYTES  read data to master 0.
- m0_ack, m0_err, m0_rty  out  1 each  terminations to master 0.
- m1_*  same set as m0_*, for master 1.
- s_cyc, s_stb, s_we  out  1 each  to slave.
- s_adr  out  ADR_W.
- s_dat_ms  out  8*DATA_BYTES.
- s_sel  out  DATA_BYTES.
- s_cti  out  3.
- s_bte  out  2.
- s_dat_sm  in  8*DATA_BYTES  slave read data.
- s_ack, s_err, s_rty  in  1 each  slave terminations.

Behaviour:
- States: IDLE, G0, G1. Register `last` records the most recently served master.
- Reset (sys_rst_n=0, asynchronous):
  - state=IDLE, last=1, hold_cnt=0.
  - All s_* outputs 0; all m*_ack/err/rty 0; m*_dat_sm 0.
  - Outputs are decoded from state, so reset mid-transaction drops s_cyc/s_stb immediately.
- IDLE:
  - s_* outputs 0.
  - If only mX_cyc=1, next state GX.
  - If both are 1, grant the master != last (m0 wins the first tie after reset).
  - Grant latency: 1 cycle from cyc assertion to s_cyc.
- GX (X granted):
  - s_cyc=mX_cyc and s_stb=mX_stb; s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte come from mX.
  - mX_ack/err/rty=s_ack/err/rty and mX_dat_sm=s_dat_sm.
  - The other master sees ack/err/rty=0 and dat_sm=0; it simply waits with cyc held.
- Release: in GX with mX_cyc=0 at a clock edge:
  - last<=X, hold_cnt<=0.
  - Next state G(other) if the other's cyc=1 (direct handover, no IDLE bubble), else IDLE.
- Hold limit (MAX_HOLD>0):
  - hold_cnt increments each cycle in GX while the other master's cyc=1, saturating at MAX_HOLD.
  - It clears on any grant change.
  - When hold_cnt==MAX_HOLD and a termination (s_ack|s_err|s_rty with s_stb) occurs in that cycle, the next state is G(other) and last<=X.
  - The preempted master keeps cyc high and is re-granted at the next release.
  - No preemption happens between terminations, so no beat is lost or duplicated.
- Grant change always takes effect on the edge after the enabling condition. The mux never routes a termination of the current beat to the newly granted master.
- Simultaneous release by X and first request by the other in the same cycle: handover to the other.
- hold_cnt width: $clog2(MAX_HOLD+1), minimum 1 bit.

Test Plan:
- Single master: m0 issues 4 single reads; slave acks 1 cycle after stb.
  - Required: s_cyc rises 1 cycle after m0_cyc; 4 m0_ack pulses carry s_dat_sm; m1 sees no ack.
- Tie after reset: m0_cyc and m1_cyc rise in the same cycle.
  - Required: grant G0 first; after m0 releases, G1 follows with no IDLE cycle between.
- Round-robin: both masters do repeated 2-beat transactions, releasing cyc between them.
  - Required: grants alternate 0,1,0,1; last toggles each time.
- Hold limit, MAX_HOLD=8: m1 holds cyc for a 32-beat burst with ack every cycle while m0 requests.
  - Required: after 8 cycles plus the pending ack, grant moves to G0; m1 receives exactly the acks issued while it was granted.
  - Required: m1 resumes after m0 releases; 32 acks total, none duplicated.
- Error/retry routing: slave returns err on a granted m1 beat.
  - Required: m1_err=1 in that cycle; m0_err stays 0.
- Reset mid-burst: assert sys_rst_n=0 during G1.
  - Required: s_cyc=0 and m1_ack=0 within the same cycle; after release, tie-break gives m0 first.
